// File: rtl/rd_interface_multi.sv
// rd_interface_multi: deserialises NLANES MSB-first serial lanes into packed
// 32-bit words and writes them into a selectable memory buffer.
// Ports:
//   SERIAL_CLK_IN / RST      sole clock, async active-high reset
//   SERIAL_DATA_IN           one serial bit per lane
//   ENABLE_XFR_IN            transfer window
//   WRT_BUF_NUM / RD_BUF_NUM buffer to fill / buffer owned by the reader
//   TRIG_IN / TRIG_OUT       trigger level in, one-cycle pulse out
//   AXI_CONTROL(_WRITTEN)    control word and its update strobe
//   DATA_ADDR / DATA_TO_MEM / ENABLE_MEM_WRT  memory write port
//   STATUS                   word count, buffer, busy and sticky flags
module rd_interface_multi #(
   parameter int NLANES     = 2,
   parameter int BITS       = 12,
   parameter int DEPTH_LOG2 = 10,
   parameter int NBUF_LOG2  = 2
) (
   input  logic                 SERIAL_CLK_IN,
   input  logic                 RST,
   input  logic [NLANES-1:0]    SERIAL_DATA_IN,
   input  logic                 ENABLE_XFR_IN,
   input  logic [NBUF_LOG2-1:0] WRT_BUF_NUM,
   input  logic [NBUF_LOG2-1:0] RD_BUF_NUM,
   input  logic                 TRIG_IN,
   input  logic [31:0]          AXI_CONTROL,
   input  logic                 AXI_CONTROL_WRITTEN,
   output logic [31:0]          DATA_ADDR,
   output logic [31:0]          DATA_TO_MEM,
   output logic                 ENABLE_MEM_WRT,
   output logic                 TRIG_OUT,
   output logic [31:0]          STATUS
);

   localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0]         CNT_ONE = 1;
   localparam logic [CW-1:0]         CNT_LAST = CW'(BITS - 1);
   localparam logic [DEPTH_LOG2:0]   IDX_ONE = 1;

   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

   state_t                       state_q, state_d;
   logic                         enable_q;
   logic                         test_q;
   logic [NBUF_LOG2-1:0]         buf_q;
   logic [CW-1:0]                bcnt_q;
   logic [DEPTH_LOG2:0]          widx_q;
   logic [NLANES-1:0][BITS-1:0]  sr_q;
   logic                         done_q;
   logic                         trig_q, trig_qq;
   logic                         trig_out_q;
   logic                         wr_q;
   logic [31:0]                  addr_q;
   logic [31:0]                  data_q;
   // [0]=overflow, [1]=collision, [2]=trigger
   logic [2:0]                   sticky_q;

   logic                         xfr_ok;
   logic                         start;
   logic                         shift_en;
   logic                         last_bit;
   logic                         do_wr;
   logic                         wr_last;
   logic                         col_set;
   logic                         ovf_set;
   logic                         trig_rise;
   logic                         sticky_clr;
   logic [31:0]                  data_w;
   logic [31:0]                  addr_w;
   logic [BITS-1:0]              pat;
   logic                         unused_ctrl;

   assign unused_ctrl = ^AXI_CONTROL[31:3];

   assign xfr_ok   = ENABLE_XFR_IN & enable_q;
   assign last_bit = (bcnt_q == CNT_LAST);

   // done_q marks a frame completed on the previous edge; the write is
   // decided one edge later, while the next frame is already shifting.
   // widx_q[DEPTH_LOG2] set means every buffer word has been written.
   assign ovf_set = done_q & widx_q[DEPTH_LOG2];
   assign col_set = done_q & ~widx_q[DEPTH_LOG2] &
                    (buf_q == RD_BUF_NUM);
   assign do_wr   = done_q & ~widx_q[DEPTH_LOG2] &
                    (buf_q != RD_BUF_NUM);
   assign wr_last = do_wr & (&widx_q[DEPTH_LOG2-1:0]);

   assign trig_rise  = trig_q & ~trig_qq;
   assign sticky_clr = AXI_CONTROL_WRITTEN & AXI_CONTROL[2];

   assign pat    = BITS'(widx_q);
   assign addr_w = 32'({buf_q, widx_q[DEPTH_LOG2-1:0], 2'b00});

   always_comb begin
      data_w = '0;
      for (int k = 0; k < NLANES; k++) begin
         data_w[k*BITS +: BITS] = test_q ? pat : sr_q[k];
      end
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfr_ok) begin
               state_d = SHIFT;
               start   = 1'b1;
            end
         end
         SHIFT, FULL: begin
            if (!xfr_ok) begin
               state_d = IDLE;
            end else begin
               shift_en = 1'b1;
               if (wr_last) state_d = FULL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SERIAL_CLK_IN or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         enable_q   <= 1'b0;
         test_q     <= 1'b0;
         buf_q      <= '0;
         bcnt_q     <= '0;
         widx_q     <= '0;
         sr_q       <= '0;
         done_q     <= 1'b0;
         trig_q     <= 1'b0;
         trig_qq    <= 1'b0;
         trig_out_q <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         sticky_q   <= '0;
      end else begin
         state_q <= state_d;
         if (AXI_CONTROL_WRITTEN) begin
            enable_q <= AXI_CONTROL[0];
            test_q   <= AXI_CONTROL[1];
         end

         done_q <= shift_en & last_bit;
         if (start) begin
            buf_q  <= WRT_BUF_NUM;
            bcnt_q <= CNT_ONE;
            widx_q <= '0;
            for (int k = 0; k < NLANES; k++) begin
               sr_q[k] <= {{(BITS-1){1'b0}}, SERIAL_DATA_IN[k]};
            end
         end else if (shift_en) begin
            bcnt_q <= last_bit ? '0 : bcnt_q + CNT_ONE;
            for (int k = 0; k < NLANES; k++) begin
               sr_q[k] <= {sr_q[k][BITS-2:0], SERIAL_DATA_IN[k]};
            end
         end

         wr_q <= do_wr;
         if (do_wr) begin
            addr_q <= addr_w;
            data_q <= data_w;
            widx_q <= widx_q + IDX_ONE;
         end

         trig_q     <= TRIG_IN;
         trig_qq    <= trig_q;
         trig_out_q <= trig_rise;

         sticky_q <= (sticky_q & ~{3{sticky_clr}}) |
                     {trig_rise, col_set, ovf_set};
      end
   end

   assign DATA_ADDR      = addr_q;
   assign DATA_TO_MEM    = data_q;
   assign ENABLE_MEM_WRT = wr_q;
   assign TRIG_OUT       = trig_out_q;

   // Word index never exceeds 2^12, so it doubles as the saturating count.
   assign STATUS[15:0]  = 16'(widx_q);
   assign STATUS[19:16] = 4'(buf_q);
   assign STATUS[23:20] = 4'b0;
   assign STATUS[24]    = (state_q != IDLE);
   assign STATUS[27:25] = sticky_q;
   assign STATUS[31:28] = 4'b0;

endmodule

// File: tb/tb_rd_interface_multi.sv
// tb_rd_interface_multi: randomized self-checking bench for
// rd_interface_multi against a frame-level reference model.
module tb_rd_interface_multi;

   localparam int NL = 2;
   localparam int BW = 12;
   localparam int DL = 10;
   localparam int NB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NL-1:0] sdi = '0;
   logic          xfr = 1'b0;
   logic [NB-1:0] wbuf = '0;
   logic [NB-1:0] rbuf = '0;
   logic          trig_in = 1'b0;
   logic [31:0]   ctrl = '0;
   logic          ctrl_wr = 1'b0;
   logic [31:0]   addr;
   logic [31:0]   data;
   logic          wr;
   logic          trig_out;
   logic [31:0]   status;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] mon_a[$];
   logic [31:0] mon_d[$];

   always #5 clk = ~clk;

   rd_interface_multi #(
      .NLANES(NL), .BITS(BW), .DEPTH_LOG2(DL), .NBUF_LOG2(NB)
   ) dut (
      .SERIAL_CLK_IN      (clk),
      .RST                (rst),
      .SERIAL_DATA_IN     (sdi),
      .ENABLE_XFR_IN      (xfr),
      .WRT_BUF_NUM        (wbuf),
      .RD_BUF_NUM         (rbuf),
      .TRIG_IN            (trig_in),
      .AXI_CONTROL        (ctrl),
      .AXI_CONTROL_WRITTEN(ctrl_wr),
      .DATA_ADDR          (addr),
      .DATA_TO_MEM        (data),
      .ENABLE_MEM_WRT     (wr),
      .TRIG_OUT           (trig_out),
      .STATUS             (status)
   );

   always @(negedge clk) begin
      if (wr === 1'b1) begin
         mon_a.push_back(addr);
         mon_d.push_back(data);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      ctrl    = v;
      ctrl_wr = 1'b1;
      step();
      ctrl_wr = 1'b0;
   endtask

   task automatic send_frame(input logic [NL-1:0][BW-1:0] w);
      for (int b = BW - 1; b >= 0; b--) begin
         for (int k = 0; k < NL; k++) sdi[k] = w[k][b];
         step();
      end
   endtask

   function automatic logic [31:0] pack(input logic [NL-1:0][BW-1:0] w);
      logic [31:0] r;
      r = 0;
      for (int k = 0; k < NL; k++) r = r + (32'(w[k]) << (k * BW));
      return r;
   endfunction

   function automatic logic [31:0] pat_word(input int idx);
      logic [31:0] r;
      r = 0;
      for (int k = 0; k < NL; k++)
         r = r + ((idx % (1 << BW)) << (k * BW));
      return r;
   endfunction

   task automatic run(input int wb, input int rb, input int nfr,
                      input bit tp, input int npart, input string tag);
      logic [NL-1:0][BW-1:0] w;
      logic [31:0] ed[$];
      int nexp;
      int bad_a;
      int bad_d;
      logic [31:0] ea;
      logic [31:0] edd;
      mon_a.delete();
      mon_d.delete();
      wbuf = NB'(wb);
      rbuf = NB'(rb);
      wr_ctrl(tp ? 32'h7 : 32'h5);
      xfr = 1'b1;
      if (npart > 0) begin
         for (int i = 0; i < npart; i++) begin
            sdi = NL'($urandom);
            step();
         end
         xfr = 1'b0;
         step();
         xfr = 1'b1;
      end
      for (int f = 0; f < nfr; f++) begin
         for (int k = 0; k < NL; k++) w[k] = BW'($urandom);
         ed.push_back(pack(w));
         send_frame(w);
      end
      xfr = 1'b0;
      repeat (3) step();
      if (wb == rb) nexp = 0;
      else if (nfr > (1 << DL)) nexp = 1 << DL;
      else nexp = nfr;
      chk({tag, "_nwr"}, mon_a.size(), nexp);
      bad_a = 0;
      bad_d = 0;
      for (int i = 0; i < mon_a.size() && i < nexp; i++) begin
         ea  = (wb << (DL + 2)) + 4 * i;
         edd = tp ? pat_word(i) : ed[i];
         if (mon_a[i] !== ea) bad_a++;
         if (mon_d[i] !== edd) bad_d++;
      end
      chk({tag, "_addr_errs"}, bad_a, 0);
      chk({tag, "_data_errs"}, bad_d, 0);
      chk({tag, "_count"}, 32'(status[15:0]), nexp);
      chk({tag, "_buf"}, 32'(status[19:16]), wb);
      chk({tag, "_busy"}, 32'(status[24]), 0);
      chk({tag, "_col"}, 32'(status[26]), (wb == rb) ? 1 : 0);
      chk({tag, "_ovf"}, 32'(status[25]),
          (wb != rb && nfr > (1 << DL)) ? 1 : 0);
   endtask

   initial begin
      logic [NL-1:0][BW-1:0] w;
      int wb, rb, nfr, np;
      bit tp;

      repeat (3) step();
      chk("rst_addr", addr, 0);
      chk("rst_data", data, 0);
      chk("rst_wr", 32'(wr), 0);
      chk("rst_trig", 32'(trig_out), 0);
      chk("rst_status", status, 0);
      rst = 1'b0;
      step();

      // trigger pulse and sticky flag
      trig_in = 1'b1;
      step();
      chk("trig_e1", 32'(trig_out), 0);
      step();
      chk("trig_e2", 32'(trig_out), 1);
      chk("trig_st", 32'(status[27]), 1);
      step();
      chk("trig_e3", 32'(trig_out), 0);
      trig_in = 1'b0;
      repeat (3) step();
      chk("trig_e6", 32'(trig_out), 0);
      chk("trig_hold", 32'(status[27]), 1);
      wr_ctrl(32'h4);
      chk("trig_clr", 32'(status[27]), 0);

      // single frame, first write latency
      wbuf = 2'd1;
      rbuf = 2'd0;
      wr_ctrl(32'h1);
      xfr = 1'b1;
      w[0] = 12'hA5A;
      w[1] = 12'h5A5;
      send_frame(w);
      xfr = 1'b0;
      chk("lat_e12", 32'(wr), 0);
      step();
      chk("lat_e13", 32'(wr), 1);
      chk("lat_data", data, 32'h005A5A5A);
      chk("lat_addr", addr, 32'h00001000);
      chk("lat_cnt", 32'(status[15:0]), 1);
      step();
      chk("lat_e14", 32'(wr), 0);

      run(2, 2, 2, 1'b0, 0, "col");
      run(1, 3, 2, 1'b0, 7, "part");
      run(3, 0, 3, 1'b1, 0, "tp");
      for (int r = 0; r < 8; r++) begin
         wb  = $urandom_range(0, 3);
         rb  = $urandom_range(0, 3);
         nfr = $urandom_range(1, 6);
         tp  = 1'($urandom_range(0, 1));
         np  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, BW - 1) : 0;
         run(wb, rb, nfr, tp, np, $sformatf("rnd%0d", r));
      end
      run(0, 1, (1 << DL) + 2, 1'b0, 0, "ovf");

      // reset in the middle of a transfer
      wbuf = 2'd1;
      rbuf = 2'd0;
      wr_ctrl(32'h1);
      xfr = 1'b1;
      for (int k = 0; k < NL; k++) w[k] = BW'($urandom);
      send_frame(w);
      repeat (5) begin
         sdi = NL'($urandom);
         step();
      end
      chk("mid_busy", 32'(status[24]), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_addr", addr, 0);
      chk("mid_data", data, 0);
      chk("mid_wr", 32'(wr), 0);
      chk("mid_status", status, 0);
      #1;
      rst = 1'b0;
      mon_a.delete();
      repeat (30) begin
         sdi = NL'($urandom);
         step();
      end
      chk("post_nwr", mon_a.size(), 0);
      chk("post_status", status, 0);
      xfr = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rd_interface_multi.md
RD_INTERFACE_MULTI -- requirements
Module: rd_interface_multi

Interface
REQ-001 SHALL have parameter NLANES, default 2, number of serial data lanes (1..4).
REQ-002 SHALL have parameter BITS, default 12, bits per serial frame per lane (2..16); NLANES*BITS SHALL be <= 32.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, log2 of words per buffer (1..12).
REQ-004 SHALL have parameter NBUF_LOG2, default 2, log2 of buffer count (1..4).
REQ-005 SHALL have ports:
  SERIAL_CLK_IN  in  1  sole clock; all logic on rising edge
  RST  in  1  reset, asynchronous, active-high
  SERIAL_DATA_IN  in  NLANES  serial data, one bit per lane, MSB first
  ENABLE_XFR_IN  in  1  transfer window
  WRT_BUF_NUM  in  NBUF_LOG2  buffer to fill
  RD_BUF_NUM  in  NBUF_LOG2  buffer currently being read by the processor
  TRIG_IN  in  1  trigger level
  AXI_CONTROL  in  32  control word
  AXI_CONTROL_WRITTEN  in  1  one-cycle strobe, AXI_CONTROL updated
  DATA_ADDR  out  32  byte address of write
  DATA_TO_MEM  out  32  packed word
  ENABLE_MEM_WRT  out  1  one-cycle write strobe
  TRIG_OUT  out  1  trigger pulse
  STATUS  out  32  status word

Function
REQ-006 SHALL register AXI_CONTROL on AXI_CONTROL_WRITTEN; bit0 = enable, bit1 = test-pattern mode, bit2 = clear STATUS sticky bits (self-clearing, acts in the strobe cycle only).
REQ-007 SHALL implement states IDLE, SHIFT, FULL.
REQ-008 IDLE->SHIFT on the first edge with ENABLE_XFR_IN=1 and enable=1; on that edge latch WRT_BUF_NUM into BUF_L, clear bit counter and word index, capture bit 0 of frame.
REQ-009 In SHIFT, each lane SHALL shift one bit per edge; after BITS bits a frame is complete and the next frame starts on the following edge with no gap.
REQ-010 On frame completion DATA_TO_MEM SHALL hold lane k word in bits [k*BITS +: BITS], unused upper bits 0; in test-pattern mode every lane word SHALL be word index[BITS-1:0] and SERIAL_DATA_IN is ignored.
REQ-011 ENABLE_MEM_WRT SHALL pulse high exactly one cycle, on the edge after the last bit of a frame is sampled (latency 1), with DATA_TO_MEM and DATA_ADDR valid in the same cycle.
REQ-012 DATA_ADDR SHALL be {zero-extension, BUF_L, word index[DEPTH_LOG2-1:0], 2'b00}; word index increments after each write.
REQ-013 If BUF_L equals RD_BUF_NUM at frame completion, the write SHALL be suppressed, word index SHALL not increment, and STATUS[26] (collision) SHALL set.
REQ-014 After 2^DEPTH_LOG2 writes the block SHALL enter FULL, issue no writes, and set STATUS[25] (overflow) on the first further completed frame.
REQ-015 ENABLE_XFR_IN=0 or enable=0 in SHIFT or FULL SHALL return to IDLE on that edge, discarding any partial frame with no write.
REQ-016 TRIG_OUT SHALL be a one-cycle pulse on the edge after a TRIG_IN rising edge is sampled, regardless of state; STATUS[27] SHALL set at the same time.
REQ-017 STATUS[15:0] SHALL be words written in current or last transfer (saturating at 0xFFFF, cleared on IDLE->SHIFT); STATUS[19:16] = BUF_L zero-extended; STATUS[24] = 1 while in SHIFT or FULL; other bits 0.
REQ-018 Sticky bits 25..27 SHALL clear only by reset or control bit2; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-019 RST=1 SHALL asynchronously force IDLE, all outputs to 0, control register to 0, BUF_L, counters, and shift registers to 0.
REQ-020 RST asserted mid-transfer SHALL abort with no further ENABLE_MEM_WRT; after release the block SHALL stay in IDLE until enable is rewritten and ENABLE_XFR_IN is high.

Verification
REQ-021 Reset: RST=1 during activity -> all outputs 0 immediately, state IDLE.
REQ-022 Defaults, enable=1, WRT_BUF_NUM=1, RD_BUF_NUM=0, lane0 0xA5A, lane1 0x5A5 -> one ENABLE_MEM_WRT on the 13th edge, DATA_TO_MEM=0x005A5A5A, DATA_ADDR=0x00001000, STATUS[15:0]=1.
REQ-023 WRT_BUF_NUM=RD_BUF_NUM=2, two frames -> no write strobes, STATUS[26]=1, STATUS[15:0]=0.
REQ-024 DEPTH_LOG2=2, six frames -> four writes at addresses base+0x0,0x4,0x8,0xC, STATUS[25]=1, STATUS[15:0]=4.
REQ-025 ENABLE_XFR_IN dropped after 7 bits, re-raised -> no write for partial frame; next write at index 0 with correctly aligned data.
REQ-026 TRIG_IN high 3 cycles -> TRIG_OUT high exactly 1 cycle, one edge after the rise; STATUS[27]=1 until control bit2 written.
